shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe.sv | 82 ++++++++
 tb/tb_shifter_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one registered
// stage per shift-amount bit, valid/ready handshake with global stall.
module shifter_pipe #(
    parameter int N     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [$clog2(N)-1:0] in_s,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_y,
    output logic [TAG_W-1:0] out_tag
);
    localparam int S = $clog2(N);

    logic [N-1:0]     r_y   [S];
    logic [S-1:0]     r_s   [S];
    logic [1:0]       r_op  [S];
    logic [TAG_W-1:0] r_tag [S];
    logic [S-1:0]     r_v;

    logic [N-1:0]     w_a  [S];
    logic [N-1:0]     w_y  [S];
    logic [S-1:0]     w_s  [S];
    logic [1:0]       w_op [S];
    logic             w_adv;

    assign w_adv     = out_ready | ~r_v[S-1];
    assign in_ready  = w_adv;
    assign out_valid = r_v[S-1];
    assign out_y     = r_y[S-1];
    assign out_tag   = r_tag[S-1];

    // stage i shifts by 2^i when amount bit i is set; SRA relies on the MSB surviving every stage
    always_comb begin
        w_a[0]  = in_a;
        w_s[0]  = in_s;
        w_op[0] = in_op;
        for (int i = 1; i < S; i++) begin
            w_a[i]  = r_y[i-1];
            w_s[i]  = r_s[i-1];
            w_op[i] = r_op[i-1];
        end
        for (int i = 0; i < S; i++) begin
            w_y[i] = !w_s[i][i] ? w_a[i] :
                     w_op[i] == 2'b00 ? w_a[i] << (1 << i) :
                     w_op[i] == 2'b01 ? w_a[i] >> (1 << i) :
                     w_op[i] == 2'b10 ? $unsigned($signed(w_a[i]) >>> (1 << i)) :
                     (w_a[i] >> (1 << i)) | (w_a[i] << (N - (1 << i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int i = 0; i < S; i++) begin
                r_y[i]   <= '0;
                r_s[i]   <= '0;
                r_op[i]  <= '0;
                r_tag[i] <= '0;
            end
        end else if (w_adv) begin
            r_v[0]   <= in_valid;
            r_tag[0] <= in_tag;
            for (int i = 1; i < S; i++) begin
                r_v[i]   <= r_v[i-1];
                r_tag[i] <= r_tag[i-1];
            end
            for (int i = 0; i < S; i++) begin
                r_y[i]  <= w_y[i];
                r_s[i]  <= w_s[i];
                r_op[i] <= w_op[i];
            end
        end
    end
endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed self-checking bench for shifter_pipe (N=32).
module tb_shifter_pipe;
    localparam int N = 32;
    localparam int S = 5;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [S-1:0]     in_s;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_y;
    logic [TAG_W-1:0] out_tag;

    int n_chk = 0;
    int n_fail = 0;

    shifter_pipe #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_s(in_s), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s,
                         input logic [1:0] op, input logic [3:0] tag);
        in_valid = v;
        in_a = a;
        in_s = s;
        in_op = op;
        in_tag = tag;
    endtask

    // one op, no stalls: out_valid must rise exactly S-1 edges after the accept edge
    task automatic single(input string name, input logic [31:0] a, input logic [4:0] s,
                          input logic [1:0] op, input logic [3:0] tag, input logic [31:0] exp);
        out_ready = 1'b1;
        drive(1'b1, a, s, op, tag);
        #1;
        chk({name, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < S - 1; j++) begin
            #1;
            chk({name, "_early"}, out_valid, 0);
            tick();
        end
        #1;
        chk({name, "_vld"}, out_valid, 1);
        chk({name, "_y"}, out_y, exp);
        chk({name, "_tag"}, out_tag, tag);
        tick();
    endtask

    logic [31:0] st_a [8] = '{32'h000000FF, 32'hF0000000, 32'hF0000000, 32'h000000FF,
                              32'h12345678, 32'h80000001, 32'h80000001, 32'hDEADBEEF};
    logic [4:0]  st_s [8] = '{5'd4, 5'd8, 5'd8, 5'd4, 5'd16, 5'd1, 5'd31, 5'd0};
    logic [1:0]  st_o [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [31:0] st_y [8] = '{32'h00000FF0, 32'h00F00000, 32'hFFF00000, 32'hF000000F,
                              32'h56781234, 32'h00000002, 32'hFFFFFFFF, 32'hDEADBEEF};

    logic [31:0] bu_a [3] = '{32'hFFFF0000, 32'h0000FFFF, 32'h80000000};
    logic [4:0]  bu_s [3] = '{5'd16, 5'd16, 5'd31};
    logic [1:0]  bu_o [3] = '{2'd1, 2'd0, 2'd2};
    logic [31:0] bu_y [4] = '{32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0BAD0BAD};
    logic [3:0]  bu_t [4] = '{4'd1, 4'd2, 4'd3, 4'hF};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int p, e, seen;
        logic acc;
        rst_n = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        drive(1'b1, $urandom, 5'($urandom), 2'($urandom), 4'($urandom));
        tick();
        tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_y", out_y, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_rdy", in_ready, 1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("idle_vld", out_valid, 0);
            chk("idle_rdy", in_ready, 1);
        end

        single("srl31", 32'h80000000, 5'd31, 2'd1, 4'd1, 32'h00000001);
        single("sra4", 32'h80000000, 5'd4, 2'd2, 4'd2, 32'hF8000000);
        single("sll31", 32'h00000001, 5'd31, 2'd0, 4'd3, 32'h80000000);
        single("ror1", 32'h00000001, 5'd1, 2'd3, 4'd4, 32'h80000000);
        single("ror8", 32'h12345678, 5'd8, 2'd3, 4'd5, 32'h78123456);
        single("sra_pos", 32'h7FFFFFFF, 5'd31, 2'd2, 4'd6, 32'h00000000);
        for (int o = 0; o < 4; o++)
            single("zero_amt", 32'hA5A5A5A5, 5'd0, 2'(o), 4'(o), 32'hA5A5A5A5);

        // streaming: 8 back-to-back ops, results in cycles 5..12
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) drive(1'b1, st_a[c], st_s[c], st_o[c], 4'(c));
            else in_valid = 1'b0;
            #1;
            chk("str_vld", out_valid, (c >= 5 && c < 13));
            if (c >= 5 && c < 13) begin
                chk("str_tag", out_tag, 32'(c - 5));
                chk("str_y", out_y, st_y[c-5]);
            end
            tick();
        end

        // backpressure: fill with out_ready low, hold, then drain
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 32'h1, 5'(c), 2'd0, 4'(8 + c));
            #1;
            chk("bp_fill_rdy", in_ready, 1);
            tick();
        end
        drive(1'b1, 32'h1, 5'd5, 2'd0, 4'd13);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_hold_rdy", in_ready, 0);
            chk("bp_hold_vld", out_valid, 1);
            chk("bp_hold_y", out_y, 32'h1);
            chk("bp_hold_tag", out_tag, 8);
            tick();
        end
        out_ready = 1'b1;
        p = 5;
        e = 0;
        for (int c = 0; c < 12; c++) begin
            if (p < 6) drive(1'b1, 32'h1, 5'(p), 2'd0, 4'(8 + p));
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                chk("bp_tag", out_tag, 32'(8 + e));
                chk("bp_y", out_y, 32'h1 << e);
                e++;
            end
            tick();
            if (acc) p++;
        end
        chk("bp_count", e, 6);

        // bubbles with random backpressure
        p = 0;
        e = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (p < 3 && c % 2 == 0) drive(1'b1, bu_a[p], bu_s[p], bu_o[p], bu_t[p]);
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bub_tag", out_tag, bu_t[e]);
                chk("bub_y", out_y, bu_y[e]);
                if (e < 3) e++;
            end
            tick();
            if (acc) p++;
        end
        chk("bub_count", e, 3);

        // reset mid-flight
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(c < 3, 32'hFFFFFFFF, 5'd1, 2'd0, 4'(4 + c));
            tick();
        end
        #1;
        chk("mid_pre_vld", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_vld", out_valid, 0);
        chk("mid_y", out_y, 0);
        chk("mid_tag", out_tag, 0);
        chk("mid_rdy", in_ready, 1);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_stale", seen, 0);
        single("post_rst", 32'h40000000, 5'd1, 2'd2, 4'd9, 32'h20000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
